// File: rtl/dco_model.sv
// Digitally controlled oscillator model: clock-divided square wave whose half-period is BASE_HALF + popcount(trim).
// Latency: osc/osc_edge/trim_err are registered (one clock after the deciding edge); running decodes the state register.
// Backpressure: none; enable stops the oscillator gracefully at the end of the current half-period.
//
// Ports:
//   clock    - system clock, all state changes on its rising edge
//   reset    - asynchronous active-high reset
//   enable   - oscillator run request
//   trim     - thermometer-coded trim, each set bit lengthens the half-period by one cycle
//   osc      - oscillator output
//   osc_edge - one-cycle pulse coincident with every osc transition
//   trim_err - trim sampled at the last reload was not a thermometer code
//   running  - high while the oscillator is running or stopping
module dco_model #(
    parameter int unsigned BASE_HALF = 4
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        enable,
    input  logic [25:0] trim,
    output logic        osc,
    output logic        osc_edge,
    output logic        trim_err,
    output logic        running
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        STOP = 2'd2
    } state_t;

    state_t      state_q, state_d;
    logic [5:0]  cnt_q, cnt_d;
    logic        osc_q, osc_d;
    logic        osc_edge_q, osc_edge_d;
    logic        trim_err_q, trim_err_d;

    logic [5:0]  trim_ones;
    logic [5:0]  hp_new;
    logic        trim_bad;

    // Half-period for the next phase; an invalid code is still honoured by its popcount.
    always_comb begin
        trim_ones = '0;
        for (int i = 0; i < 26; i++) begin
            trim_ones = trim_ones + {5'd0, trim[i]};
        end
        hp_new = 6'(BASE_HALF) + trim_ones;
    end

    // A thermometer code 2^k-1 has no set bit above a clear bit, so adding one clears every set bit.
    assign trim_bad = |(trim & (trim + 26'd1));

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        osc_d      = osc_q;
        osc_edge_d = 1'b0;
        trim_err_d = trim_err_q;

        case (state_q)
            IDLE: begin
                osc_d = 1'b0;
                cnt_d = '0;
                if (enable) begin
                    cnt_d      = hp_new;
                    trim_err_d = trim_bad;
                    state_d    = RUN;
                end
            end

            RUN: begin
                if (cnt_q == 6'd1) begin
                    osc_d      = ~osc_q;
                    osc_edge_d = 1'b1;
                    cnt_d      = hp_new;
                    trim_err_d = trim_bad;
                end else begin
                    cnt_d = cnt_q - 6'd1;
                end
                // Stopping only changes what happens at the end of a phase, never its length.
                if (!enable) begin
                    state_d = STOP;
                end
            end

            STOP: begin
                if (cnt_q == 6'd1) begin
                    // Phase ends: park low, emitting an edge only if we were high.
                    osc_d      = 1'b0;
                    osc_edge_d = osc_q;
                    cnt_d      = '0;
                    state_d    = IDLE;
                end else begin
                    cnt_d = cnt_q - 6'd1;
                    if (enable) begin
                        state_d = RUN;
                    end
                end
            end

            default: begin
                state_d = IDLE;
                cnt_d   = '0;
                osc_d   = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            osc_q      <= 1'b0;
            osc_edge_q <= 1'b0;
            trim_err_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            osc_q      <= osc_d;
            osc_edge_q <= osc_edge_d;
            trim_err_q <= trim_err_d;
        end
    end

    assign osc      = osc_q;
    assign osc_edge = osc_edge_q;
    assign trim_err = trim_err_q;
    assign running  = (state_q != IDLE);

endmodule

// File: tb/tb_dco_model.sv
// Testbench for dco_model: directed scenarios plus randomized stimulus against a phase-level reference model.
// Latency: outputs compared 1 ns after every rising clock edge.
// Backpressure: none.
module tb_dco_model;

    logic        clock = 1'b0;
    logic        reset;
    logic        enable;
    logic [25:0] trim;
    logic        osc;
    logic        osc_edge;
    logic        trim_err;
    logic        running;

    dco_model #(.BASE_HALF(4)) dut (
        .clock    (clock),
        .reset    (reset),
        .enable   (enable),
        .trim     (trim),
        .osc      (osc),
        .osc_edge (osc_edge),
        .trim_err (trim_err),
        .running  (running)
    );

    always #5 clock = ~clock;

    int n_chk  = 0;
    int n_fail = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0d exp=%0d at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference model: a phase has a length fixed when it starts and an elapsed-cycle count.
    bit m_active;    // oscillator running (covers both running and stopping)
    bit m_stopping;  // current phase is the last one
    bit m_osc;
    bit m_edge;
    bit m_err;
    int m_elapsed;
    int m_len;

    function automatic int half_of(input logic [25:0] t);
        return 4 + $countones(t);
    endfunction

    function automatic bit bad_of(input logic [25:0] t);
        for (int k = 0; k <= 26; k++) begin
            if (t == 26'((64'd1 << k) - 64'd1)) return 1'b0;
        end
        return 1'b1;
    endfunction

    task automatic model_reset();
        m_active   = 0;
        m_stopping = 0;
        m_osc      = 0;
        m_edge     = 0;
        m_err      = 0;
        m_elapsed  = 0;
        m_len      = 0;
    endtask

    task automatic model_tick();
        m_edge = 0;
        if (!m_active) begin
            if (enable) begin
                m_active   = 1;
                m_stopping = 0;
                m_len      = half_of(trim);
                m_err      = bad_of(trim);
                m_elapsed  = 0;
            end
        end else begin
            m_elapsed++;
            if (m_elapsed == m_len) begin
                if (m_stopping) begin
                    m_edge   = m_osc;
                    m_osc    = 0;
                    m_active = 0;
                end else begin
                    m_osc     = !m_osc;
                    m_edge    = 1;
                    m_len     = half_of(trim);
                    m_err     = bad_of(trim);
                    m_elapsed = 0;
                end
            end
            if (m_active) m_stopping = !enable;
        end
    endtask

    task automatic step();
        @(posedge clock);
        if (reset) model_reset();
        else model_tick();
        #1;
        chk("osc", osc, m_osc);
        chk("osc_edge", osc_edge, m_edge);
        chk("trim_err", trim_err, m_err);
        chk("running", running, m_active);
    endtask

    task automatic count_to_edge(input string tag, input int exp);
        int n = 0;
        do begin
            step();
            n++;
        end while (!osc_edge && n < 200);
        chk(tag, n, exp);
    endtask

    task automatic wait_rise();
        for (int i = 0; i < 200; i++) begin
            step();
            if (osc_edge && osc) return;
        end
        chk("rise_timeout", 0, 1);
    endtask

    task automatic measure(input string tag, input int exp);
        count_to_edge({tag, "_sync"}, -1 == 0 ? 0 : 0);
        n_chk--;  // alignment only; not a check of its own
        count_to_edge(tag, exp);
    endtask

    initial begin
        reset  = 1'b1;
        enable = 1'b0;
        trim   = '0;
        #2;
        model_reset();
        chk("rst_osc", osc, 0);
        chk("rst_edge", osc_edge, 0);
        chk("rst_err", trim_err, 0);
        chk("rst_running", running, 0);
        #10 reset = 1'b0;

        // Idle without enable: nothing happens.
        repeat (3) step();

        // Nominal and trimmed half-periods.
        enable = 1'b1;
        count_to_edge("first_toggle", 5);
        count_to_edge("hp_trim0", 4);
        trim = 26'h000000F;
        count_to_edge("reload_F", 4);
        count_to_edge("hp_trimF", 8);
        trim = 26'h3FFFFFF;
        count_to_edge("reload_all", 8);
        count_to_edge("hp_trim_all", 30);
        trim = 26'h0000005;
        count_to_edge("reload_5", 30);
        chk("err_trim5", trim_err, 1);
        count_to_edge("hp_trim5", 6);
        trim = 26'h0000003;
        count_to_edge("reload_3", 6);
        chk("err_trim3", trim_err, 0);
        count_to_edge("hp_trim3", 6);

        // Mid-phase trim change only affects the following phase.
        trim = '0;
        count_to_edge("reload_0", 6);
        repeat (2) step();
        trim = 26'h00000FF;
        count_to_edge("cur_phase_kept", 2);
        count_to_edge("hp_trimFF", 12);

        // Drop enable two cycles into a high phase.
        trim = '0;
        count_to_edge("reload_0b", 12);
        wait_rise();
        repeat (2) step();
        enable = 1'b0;
        begin
            int n = 0;
            do begin
                step();
                n++;
            end while (osc && n < 50);
            chk("stop_fall", n, 2);
            chk("stop_running", running, 0);
        end
        repeat (10) step();

        // Re-enable while stopping: no phase disturbance.
        enable = 1'b1;
        wait_rise();
        step();
        enable = 1'b0;
        step();
        enable = 1'b1;
        count_to_edge("reenable_fall", 2);
        count_to_edge("reenable_hp", 4);

        // Asynchronous reset in mid high phase.
        wait_rise();
        step();
        #2 reset = 1'b1;
        #1;
        model_reset();
        chk("async_osc", osc, 0);
        chk("async_running", running, 0);
        chk("async_edge", osc_edge, 0);
        repeat (2) step();
        reset = 1'b0;
        count_to_edge("post_reset_toggle", 5);

        // Randomized run.
        for (int c = 0; c < 4000; c++) begin
            if ($urandom_range(0, 49) == 0) enable = ($urandom_range(0, 9) < 8);
            if ($urandom_range(0, 9) == 0) begin
                if ($urandom_range(0, 1) == 0) begin
                    int k;
                    k = $urandom_range(0, 26);
                    trim = 26'((64'd1 << k) - 64'd1);
                end else begin
                    trim = 26'($urandom);
                end
            end
            if ($urandom_range(0, 499) == 0) begin
                reset = 1'b1;
                #1;
                model_reset();
                chk("rnd_async_running", running, 0);
                step();
                reset = 1'b0;
            end
            step();
        end

        $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
        $finish;
    end

endmodule

// File: doc/dco_model.md
DCO_MODEL -- requirements
Module: dco_model

Interface
REQ-001 SHALL have parameter BASE_HALF, default 4, meaning the half-period in clock cycles for trim = 0 (legal range 1..31).
REQ-002 SHALL have port clock, input, 1, the single system clock; all state updates occur on its rising edge.
REQ-003 SHALL have port reset, input, 1, asynchronous active-high reset.
REQ-004 SHALL have port enable, input, 1, oscillator run request.
REQ-005 SHALL have port trim, input, 26, thermometer-coded delay trim; each set bit adds one clock cycle to the half-period.
REQ-006 SHALL have port osc, output, 1, generated oscillator output, registered.
REQ-007 SHALL have port osc_edge, output, 1, one-cycle pulse on every osc transition, registered.
REQ-008 SHALL have port trim_err, output, 1, registered flag: last sampled trim was not a valid thermometer code.
REQ-009 SHALL have port running, output, 1, high while in RUN or STOP state.

Function
REQ-010 SHALL compute hp_new = BASE_HALF + popcount(trim), 6-bit unsigned (range BASE_HALF..BASE_HALF+26, no overflow).
REQ-011 SHALL sample trim only at a reload instant: the IDLE->RUN transition, and each cycle where cnt == 1 in RUN.
REQ-012 SHALL use a 6-bit down-counter cnt and a three-state FSM: IDLE, RUN, STOP.
REQ-013 IDLE: osc = 0, cnt = 0, running = 0; when enable = 1, load cnt <= hp_new, go to RUN; osc stays 0.
REQ-014 RUN with cnt != 1: cnt <= cnt - 1; osc unchanged; osc_edge = 0.
REQ-015 RUN with cnt == 1: osc <= ~osc, osc_edge <= 1, cnt <= hp_new; each half-period therefore lasts exactly hp_new clock cycles.
REQ-016 RUN with enable = 0: go to STOP in the same cycle; counting continues unchanged (a reload in that cycle still occurs).
REQ-017 STOP with cnt != 1: cnt <= cnt - 1; enable = 1 returns to RUN without touching cnt or osc.
REQ-018 STOP with cnt == 1: osc <= 0, cnt <= 0, go to IDLE; osc_edge <= 1 only if osc was 1; this holds even if enable = 1 that cycle.
REQ-019 osc SHALL never produce a high or low phase shorter than the half-period in effect when it started.
REQ-020 trim_err SHALL be updated only at reload instants: 1 when trim is not of the form 2^k - 1 (k = 0..26), else 0; it holds between reloads.
REQ-021 An invalid trim SHALL still be used: hp_new uses the popcount regardless of trim_err.
REQ-022 trim changes between reload instants SHALL have no effect on the current half-period.

Reset
REQ-023 reset = 1 SHALL asynchronously force state IDLE, cnt = 0, osc = 0, osc_edge = 0, trim_err = 0 and running = 0, including mid-phase.
REQ-024 After reset deasserts, the first reload SHALL occur no earlier than the first rising clock edge where enable = 1.

Verification
REQ-025 BASE_HALF = 4, 10 ns clock, trim = 0, enable = 1 -> osc period 80 ns (4 high / 4 low cycles), trim_err = 0, one osc_edge per toggle.
REQ-026 trim = 26'h000000F -> half-period 8 cycles, 160 ns period; trim = 26'h3FFFFFF -> half-period 30 cycles, 600 ns period.
REQ-027 Change trim from 0 to 26'h00000FF in mid-phase -> current phase completes at 4 cycles, the next phase lasts 12 cycles.
REQ-028 trim = 26'h0000005 -> trim_err = 1 after the next reload, half-period 6 cycles; then trim = 26'h0000003 -> trim_err = 0 after the following reload.
REQ-029 Drop enable 2 cycles into a high phase (trim = 0) -> osc falls exactly 2 cycles later, running falls with it, no further edges; re-assert enable during STOP -> oscillation continues with no phase disturbance.
REQ-030 Assert reset mid high phase -> osc = 0 and running = 0 immediately, without waiting for a clock edge; release reset with enable = 1 -> first toggle occurs hp_new cycles after the first clock edge following reset release.
